boron_key_schedule: RTL and testbench

- Iterative Boron-80 key schedule that sits directly upstream of the encryption and decryption cores.
- Latches an 80-bit master key and computes the 26 round keys RK0..RK25, one per cycle, into an internal buffer.
- Serves random-access indexed reads, so encryption can walk RK0→RK25 and decryption can walk RK25→RK0 from one schedule run.

---
 rtl/boron_key_schedule_pkg.sv | 55 +++++
 rtl/boron_key_schedule_if.sv | 25 ++
 rtl/boron_key_schedule_rk_buffer.sv | 57 +++++
 rtl/boron_key_schedule.sv | 85 ++++++++
 tb/tb_boron_key_schedule.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/boron_key_schedule_pkg.sv
// Shared Boron-80 definitions: sizes, FSM encoding, S-box and key-update function.
// The S-box is also used by the encryption round, so it lives here, not in the key schedule.
package boron_pkg;

    localparam int NROUNDS = 25;
    localparam int KEY_W   = 80;
    localparam int RK_W    = 64;
    localparam int BLK_W   = 64;
    localparam int NUM_RK  = NROUNDS + 1;
    localparam int IDX_W   = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GEN   = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    typedef struct packed {
        logic [RK_W-1:0] rk;
        logic            valid;
        logic            err;
    } boron_rd_rsp_t;

    function automatic logic [3:0] boron_sbox(input logic [3:0] i_nib);
        logic [3:0] w_out;
        case (i_nib)
            4'h0: w_out = 4'hE;
            4'h1: w_out = 4'h4;
            4'h2: w_out = 4'hB;
            4'h3: w_out = 4'h1;
            4'h4: w_out = 4'h7;
            4'h5: w_out = 4'h9;
            4'h6: w_out = 4'hC;
            4'h7: w_out = 4'hA;
            4'h8: w_out = 4'hD;
            4'h9: w_out = 4'h2;
            4'hA: w_out = 4'h0;
            4'hB: w_out = 4'hF;
            4'hC: w_out = 4'h8;
            4'hD: w_out = 4'h5;
            4'hE: w_out = 4'h3;
            default: w_out = 4'h6;
        endcase
        return w_out;
    endfunction

    // Rotate left by 13, substitute the low nibble, then mix the round counter into bits 63:59.
    function automatic logic [KEY_W-1:0] boron_key_update(input logic [KEY_W-1:0] i_key,
                                                          input logic [4:0]       i_round);
        logic [KEY_W-1:0] w_k;
        w_k        = {i_key[KEY_W-14:0], i_key[KEY_W-1:KEY_W-13]};
        w_k[3:0]   = boron_sbox(w_k[3:0]);
        w_k[63:59] = w_k[63:59] ^ i_round;
        return w_k;
    endfunction

endpackage

// File: rtl/boron_key_schedule_if.sv
// Request/response bundle between the key schedule and its user (cipher cores or a bench).
interface boron_key_schedule_if;
    import boron_pkg::*;

    logic                start;
    logic [KEY_W-1:0]    key;
    logic                busy;
    logic                ready;
    logic                rd_en;
    logic [IDX_W-1:0]    rd_idx;
    logic [RK_W-1:0]     rk_out;
    logic                rk_valid;
    logic                rd_err;

    modport master (
        output start, key, rd_en, rd_idx,
        input  busy, ready, rk_out, rk_valid, rd_err
    );

    modport slave (
        input  start, key, rd_en, rd_idx,
        output busy, ready, rk_out, rk_valid, rd_err
    );

endinterface

// File: rtl/boron_key_schedule_rk_buffer.sv
// Round-key register file: one synchronous write port, one registered and range-checked read port.
// Storage is never cleared; the caller's i_rd_allow decides whether contents may be trusted.
module boron_rk_buffer
    import boron_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [RK_W-1:0]   i_wdata,
    input  logic              i_rd_en,
    input  logic              i_rd_allow,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [RK_W-1:0]   o_rk_out,
    output logic              o_rk_valid,
    output logic              o_rd_err
);

    logic [RK_W-1:0] r_mem [NUM_RK];
    boron_rd_rsp_t   r_rsp;
    logic            w_widx_ok;
    logic            w_ridx_ok;

    assign w_widx_ok = (i_waddr  <= IDX_W'(NROUNDS));
    assign w_ridx_ok = (i_rd_idx <= IDX_W'(NROUNDS));

    always_ff @(posedge clk) begin
        if (i_we && w_widx_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A rejected read drives zero data; an idle cycle keeps the last key on rk_out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsp <= '0;
        end else if (i_rd_en) begin
            if (i_rd_allow && w_ridx_ok) begin
                r_rsp.rk    <= r_mem[i_rd_idx];
                r_rsp.valid <= 1'b1;
                r_rsp.err   <= 1'b0;
            end else begin
                r_rsp.rk    <= '0;
                r_rsp.valid <= 1'b0;
                r_rsp.err   <= 1'b1;
            end
        end else begin
            r_rsp.valid <= 1'b0;
            r_rsp.err   <= 1'b0;
        end
    end

    assign o_rk_out   = r_rsp.rk;
    assign o_rk_valid = r_rsp.valid;
    assign o_rd_err   = r_rsp.err;

endmodule

// File: rtl/boron_key_schedule.sv
// Iterative Boron-80 key schedule: generates RK0..RK25 one per cycle into a buffer,
// then serves random-access reads so encryption and decryption share one schedule run.
module boron_key_schedule
    import boron_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    boron_key_schedule_if.slave  bus
);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_rc;
    logic [KEY_W-1:0]  r_key;
    logic              r_busy;

    logic              w_ready;
    logic              w_last;
    logic              w_load;
    logic              w_we;
    logic [IDX_W-1:0]  w_next_rc;
    logic [RK_W-1:0]   w_rk_out;
    logic              w_rk_valid;
    logic              w_rd_err;

    assign w_ready   = (r_state == ST_READY);
    assign w_last    = (r_rc == IDX_W'(NROUNDS));
    assign w_next_rc = r_rc + 1'b1;
    // start is only honoured outside generation, so a run in progress always completes.
    assign w_load    = bus.start && (r_state != ST_GEN);
    assign w_we      = (r_state == ST_GEN) && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_rc    <= '0;
            r_key   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (r_state == ST_GEN);
            case (r_state)
                ST_IDLE, ST_READY: begin
                    if (w_load) begin
                        r_key   <= bus.key;
                        r_rc    <= '0;
                        r_state <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    if (w_last) begin
                        r_state <= ST_READY;
                    end else begin
                        r_key <= boron_key_update(r_key, w_next_rc);
                        r_rc  <= w_next_rc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reads are judged against the state before this edge, so a same-cycle re-key
    // still returns a key from the old schedule.
    boron_rk_buffer u_rk_buffer (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we),
        .i_waddr    (r_rc),
        .i_wdata    (r_key[RK_W-1:0]),
        .i_rd_en    (bus.rd_en),
        .i_rd_allow (w_ready),
        .i_rd_idx   (bus.rd_idx),
        .o_rk_out   (w_rk_out),
        .o_rk_valid (w_rk_valid),
        .o_rd_err   (w_rd_err)
    );

    assign bus.busy     = r_busy;
    assign bus.ready    = w_ready;
    assign bus.rk_out   = w_rk_out;
    assign bus.rk_valid = w_rk_valid;
    assign bus.rd_err   = w_rd_err;

endmodule

// File: tb/tb_boron_key_schedule.sv
// Self-checking bench for boron_key_schedule: directed sequence with random keys
// checked against a plain-arithmetic model of the Boron-80 key schedule.
module tb_boron_key_schedule;

   logic clk;
   logic rst;
   int   passCount;
   int   checkCount;

   logic [3:0]  sboxTable [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                   4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
   logic [79:0] keyA;
   logic [79:0] keyB;
   logic [79:0] keyC;
   logic [79:0] keyD;
   int          latency;

   boron_key_schedule_if bus ();

   boron_key_schedule dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: round key idx of master key mk, straight from the schedule rules.
   function automatic logic [63:0] refRoundKey(input logic [79:0] mk, input int idx);
      logic [79:0] k;
      k = mk;
      for (int r = 1; r <= idx; r++) begin
         k = (k << 13) | (k >> 67);
         k[3:0] = sboxTable[k[3:0]];
         k[63:59] = k[63:59] ^ 5'(r);
      end
      return k[63:0];
   endfunction

   function automatic logic [79:0] randomKey();
      return {16'($urandom), $urandom, $urandom};
   endfunction

   // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
   task automatic applyStimulus(input logic rstN, input logic st, input logic [79:0] k,
                                input logic re, input logic [4:0] idx);
      @(negedge clk);
      rst        = rstN;
      bus.start  = st;
      bus.key    = k;
      bus.rd_en  = re;
      bus.rd_idx = idx;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [79:0] observed,
                              input logic [79:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic checkRead(input string tag, input logic [63:0] expRk,
                            input logic expValid, input logic expErr);
      checkOutput({tag, " rk_out"}, 80'(bus.rk_out), 80'(expRk));
      checkOutput({tag, " rk_valid"}, 80'(bus.rk_valid), 80'(expValid));
      checkOutput({tag, " rd_err"}, 80'(bus.rd_err), 80'(expErr));
   endtask

   task automatic waitForReady(output int cycles);
      cycles = -1;
      for (int c = 1; c <= 60; c++) begin
         applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
         if (bus.ready === 1'b1) begin
            cycles = c;
            break;
         end
      end
   endtask

   task automatic readAll(input string tag, input logic [79:0] mk, input logic descending);
      int idx;
      for (int i = 0; i < 26; i++) begin
         idx = descending ? 25 - i : i;
         applyStimulus(1'b1, 1'b0, '0, 1'b1, 5'(idx));
         checkRead($sformatf("%s idx%0d", tag, idx), refRoundKey(mk, idx), 1'b1, 1'b0);
      end
   endtask

   initial begin
      passCount  = 0;
      checkCount = 0;
      rst        = 1'b0;
      bus.start  = 1'b0;
      bus.key    = '0;
      bus.rd_en  = 1'b0;
      bus.rd_idx = '0;
      keyA = randomKey();
      keyB = randomKey();
      keyC = randomKey();
      keyD = randomKey();

      $display("[TB] reset");
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      checkOutput("reset busy", 80'(bus.busy), 80'(0));
      checkOutput("reset ready", 80'(bus.ready), 80'(0));
      checkRead("reset", 64'h0, 1'b0, 1'b0);

      $display("[TB] zero key schedule");
      applyStimulus(1'b1, 1'b1, 80'h0, 1'b0, '0);
      waitForReady(latency);
      checkOutput("zero key latency", 80'(latency), 80'(26));
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 5'd0);
      checkRead("zero key idx0", 64'h0000000000000000, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 5'd1);
      checkRead("zero key idx1", 64'h080000000000000E, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
      checkRead("idle hold", 64'h080000000000000E, 1'b0, 1'b0);

      $display("[TB] random key A, mid-GEN read and ignored start");
      latency = -1;
      applyStimulus(1'b1, 1'b1, keyA, 1'b0, '0);
      for (int c = 1; c <= 60; c++) begin
         applyStimulus(1'b1, (c == 5), keyB, (c == 3), 5'd2);
         if (c == 3) checkRead("read during GEN", 64'h0, 1'b0, 1'b1);
         if (c == 10) checkOutput("busy mid GEN", 80'(bus.busy), 80'(1));
         if (bus.ready === 1'b1) begin
            latency = c;
            break;
         end
      end
      checkOutput("key A latency", 80'(latency), 80'(26));
      readAll("key A up", keyA, 1'b0);
      readAll("key A down", keyA, 1'b1);
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 5'd26);
      checkRead("idx26", 64'h0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 5'd31);
      checkRead("idx31", 64'h0, 1'b0, 1'b1);

      $display("[TB] re-key with same-cycle read");
      applyStimulus(1'b1, 1'b1, keyC, 1'b1, 5'd5);
      checkRead("rekey read idx5", refRoundKey(keyA, 5), 1'b1, 1'b0);
      checkOutput("rekey ready drop", 80'(bus.ready), 80'(0));
      waitForReady(latency);
      checkOutput("key C latency", 80'(latency), 80'(26));
      readAll("key C up", keyC, 1'b0);

      $display("[TB] reset during generation");
      applyStimulus(1'b1, 1'b1, keyD, 1'b0, '0);
      for (int c = 1; c <= 9; c++) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      checkOutput("mid reset busy", 80'(bus.busy), 80'(0));
      checkOutput("mid reset ready", 80'(bus.ready), 80'(0));
      checkRead("mid reset", 64'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 5'd0);
      checkRead("read after reset", 64'h0, 1'b0, 1'b1);
      for (int c = 1; c <= 30; c++) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
      checkOutput("ready stays low", 80'(bus.ready), 80'(0));
      checkOutput("busy stays low", 80'(bus.busy), 80'(0));
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 5'd7);
      checkRead("read idle after reset", 64'h0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, keyD, 1'b0, '0);
      waitForReady(latency);
      checkOutput("key D latency", 80'(latency), 80'(26));
      readAll("key D down", keyD, 1'b1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
